layer_sequencer: RTL and testbench

//  Top-level scheduler for the CNN inference pipeline: runs NUM_LAYERS layer engines
//  (conv, pool, dense controllers) strictly in order, index 0 first, one at a time.
//  Per layer: issue a 1-cycle start pulse, wait for busy to rise, then wait for it to fall.

---
 rtl/layer_sequencer.sv | 126 ++++++++++++
 tb/tb_layer_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Runs NUM_LAYERS layer engines strictly in order behind one host start/busy/done handshake.
// Optional per-wait-state watchdog is compiled in with `define LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int LAYER_W        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_busy,
  input  logic [NUM_LAYERS-1:0] layer_valid,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic                  busy,
  output logic                  done,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic                  result_valid,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [LAYER_W-1:0]    layer_q, layer_nx;
  logic [NUM_LAYERS-1:0] sel;
  logic                  sel_busy;
  logic                  is_last;
  logic                  wd_expired;

  // Only the last engine's valid is observed; the rest are intentionally dropped.
  logic valid_unused;
  assign valid_unused = ^layer_valid;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      sel[i] = (layer_q == LAYER_W'(i));
    end
    sel_busy = |(layer_busy & sel);
    is_last  = (layer_q == LAYER_W'(NUM_LAYERS - 1));
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_expired = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state_nx == S_WAIT_BUSY && state != S_WAIT_BUSY) ||
                 (state_nx == S_RUN && state != S_RUN)) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT_BUSY || state == S_RUN) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      layer_q <= '0;
    end else begin
      state   <= state_nx;
      layer_q <= layer_nx;
    end
  end

  // NOTE: defaults first, so every path assigns every variable and no latch is inferred.
  always_comb begin
    state_nx = state;
    layer_nx = layer_q;
    unique case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_nx = S_LAUNCH;
          layer_nx = '0;
        end
      end
      S_LAUNCH: state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (sel_busy)        state_nx = S_RUN;
        else if (wd_expired) state_nx = S_ERROR;
      end
      S_RUN: begin
        if (!sel_busy)       state_nx = S_NEXT;
        else if (wd_expired) state_nx = S_ERROR;
      end
      S_NEXT: begin
        if (is_last) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_LAUNCH;
          layer_nx = layer_q + LAYER_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        layer_nx = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore decode; result_valid is the only output that passes an input straight through.
  always_comb begin
    layer_start  = (state == S_LAUNCH) ? sel : '0;
    busy         = state inside {S_LAUNCH, S_WAIT_BUSY, S_RUN, S_NEXT, S_DONE};
    done         = (state == S_DONE);
    cur_layer    = layer_q;
    result_valid = (state == S_RUN) && is_last && layer_valid[NUM_LAYERS-1];
`ifdef LAYER_SEQ_TIMEOUT_EN
    error        = (state == S_ERROR);
`else
    error        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: randomized engine timing and cross-layer noise,
// expected launch/done events predicted from handshake timing rules.
module tb_layer_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] layer_busy;
  logic [N-1:0] layer_valid;
  logic [N-1:0] layer_start;
  logic         busy, done, result_valid, error;
  logic [1:0]   cur_layer;

  layer_sequencer #(.NUM_LAYERS(N), .LAYER_W(2), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_busy(layer_busy),
    .layer_valid(layer_valid), .layer_start(layer_start), .busy(busy), .done(done),
    .cur_layer(cur_layer), .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int layer;
    int edge_no;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edges = 0;
  int   done_count = 0;
  int   done_edge = -10;
  int   launch0_cnt = 0;
  int   launch_edge [N];

  // engine model state
  int       eng_phase = 0;
  int       eng_k = 0;
  int       eng_cnt = 0;
  int       cur_k = N - 1;
  int       stall_layer = -1;
  bit       force_long = 1'b0;
  bit       in_last_run = 1'b0;
  logic [N-1:0] eng_busy = '0;
  logic [N-1:0] noise_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  // Engine models: respond to a launch after 1-3 cycles, hold busy 1-6 cycles.
  always @(negedge clk) begin
    if (rst) begin
      eng_phase   = 0;
      cur_k       = N - 1;
      in_last_run = 1'b0;
      eng_busy    = '0;
    end else begin
      case (eng_phase)
        0: if (layer_start != '0) begin
          for (int i = 0; i < N; i++) if (layer_start[i]) eng_k = i;
          cur_k = eng_k;
          if (eng_k != stall_layer) begin
            eng_cnt   = $urandom_range(1, 3);
            eng_phase = 1;
          end
        end
        1: begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_busy[eng_k] = 1'b1;
            in_last_run     = (eng_k == N - 1);
            eng_cnt         = force_long ? 8 : $urandom_range(1, 6);
            eng_phase       = 2;
          end
        end
        default: begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_busy[eng_k] = 1'b0;
            in_last_run     = 1'b0;
            eng_phase       = 0;
            // busy low sampled next edge -> NEXT, then LAUNCH/DONE one edge later
            if (eng_k == N - 1) begin
              sb.push_back('{1'b1, 0, edges + 2});
              if (start) sb.push_back('{1'b0, 0, edges + 4});
            end else begin
              sb.push_back('{1'b0, eng_k + 1, edges + 2});
            end
          end
        end
      endcase
    end
    for (int j = 0; j < N; j++) noise_busy[j] = (j == cur_k) ? 1'b0 : 1'($urandom_range(0, 1));
    layer_busy  = eng_busy | noise_busy;
    layer_valid = N'($urandom);
  end

  // Monitor: pops the scoreboard whenever the DUT emits a launch or done pulse.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (layer_start != '0 || done) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {27'd0, done, layer_start}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_edge", edges, e.edge_no);
          if (e.is_done) begin
            check("done_pulse", {27'd0, done, layer_start}, 32'h10);
            check("busy_at_done", busy, 1);
            done_edge = edges;
            done_count++;
          end else begin
            check("launch_onehot", {27'd0, done, layer_start}, 32'(1 << e.layer));
            check("launch_cur_layer", cur_layer, e.layer);
            check("launch_error_clear", error, 0);
            launch_edge[e.layer] = edges;
            if (e.layer == 0) launch0_cnt++;
          end
        end
      end
      if (edges == done_edge + 1) check("busy_after_done", busy, 0);
      check("result_valid", result_valid, in_last_run && layer_valid[N-1]);
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_start(input int gap);
    repeat (gap) at_neg();
    start = 1'b1;
    sb.push_back('{1'b0, 0, edges + 1});
    at_neg();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("run_completes", done_count, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_layer_start"}, layer_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cur_layer"}, cur_layer, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    check_idle_outputs("reset");
    at_neg();
    rst = 1'b0;

    // single one-cycle start, then randomized back-to-back runs
    issue_start(2);
    wait_done(1);
    for (int r = 0; r < 6; r++) begin
      issue_start($urandom_range(2, 5));
      wait_done(done_count + 1);
    end

    // start held across two runs: restart 2 cycles after done
    base = launch0_cnt;
    repeat (2) at_neg();
    start = 1'b1;
    sb.push_back('{1'b0, 0, edges + 1});
    n = 0;
    while (launch0_cnt < base + 2 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("held_start_restart", launch0_cnt, base + 2);
    at_neg();
    start = 1'b0;
    wait_done(done_count + 1);

    // reset while layer 2 is in RUN
    force_long = 1'b1;
    base = done_count;
    issue_start(3);
    n = 0;
    while (!(eng_phase == 2 && eng_k == 2) && n < 3000) begin
      at_neg();
      n++;
    end
    check("reach_layer2_run", eng_k, 2);
    at_neg();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #2;
    check_idle_outputs("midrun_reset");
    at_neg();
    rst = 1'b0;
    force_long = 1'b0;
    repeat (12) at_neg();
    check("no_run_after_reset", busy, 0);
    check("no_done_after_reset", done_count, base);

    issue_start(2);
    wait_done(done_count + 1);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // layer 1 never answers: watchdog fires after 20 cycles in WAIT_BUSY
    stall_layer = 1;
    base = done_count;
    launch_edge[1] = -1;
    issue_start(3);
    n = 0;
    while (error !== 1'b1 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("timeout_error", error, 1);
    check("timeout_latency", edges - launch_edge[1], 21);
    check("timeout_cur_layer", cur_layer, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", done_count, base);
    stall_layer = -1;
    issue_start(2);
    check("error_cleared", error, 0);
    wait_done(done_count + 1);
`endif

    repeat (4) at_neg();
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
